gray_encoder_stream: RTL and testbench

- Upstream feeder for decoder_gray: produces an 8-bit Gray-coded data stream plus the matching 3-bit decoder enable pattern.
- Two sources:
  - pass-through mode: binary words accepted on a valid/ready input and encoded.
  - count mode: internal ranged counter generating a Gray sequence.
- Output passes through a 2-entry buffer, so backpressure never drops or corrupts words.

---
 rtl/gray_pkg.sv | 18 +
 rtl/gray_obuf.sv | 64 ++++++
 rtl/gray_encoder_stream.sv | 147 ++++++++++++++
 tb/tb_gray_encoder_stream.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared constants, FSM state type and Gray conversion helper for gray_encoder_stream.
package gray_pkg;

  localparam logic [2:0] EN_ACTIVE = 3'b100;
  localparam logic [2:0] EN_IDLE   = 3'b000;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } state_e;

  // Callers zero-extend into 32 bits and cast the result back, so any WIDTH <= 32 works.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_obuf.sv
// Two-entry valid/ready output FIFO; head register drives dout_o directly.
module gray_obuf #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             full_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] dout_o,
  input  logic             ready_i
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             pop;

  assign valid_o = (cnt_q != 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign dout_o  = head_q;
  assign pop     = valid_o && ready_i;

  // The writer never pushes into a full buffer, so push-without-pop only sees counts 0 and 1.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({push_i, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = din_i;
        else               tail_d = din_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = din_i;
        end else begin
          head_d = tail_q;
          tail_d = din_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/gray_encoder_stream.sv
// Gray-coded stream source (pass-through or ranged count) feeding decoder_gray.
// Define GRAY_ENC_CHECK_EN to add err_o and the single-bit-step checker on popped count words.
module gray_encoder_stream
  import gray_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] bin_i,
  input  logic             bin_valid_i,
  output logic             bin_ready_o,
  input  logic             start_i,
  input  logic [WIDTH-1:0] first_i,
  input  logic [WIDTH-1:0] last_i,
  input  logic             abort_i,
  output logic             done_o,
  output logic [WIDTH-1:0] gray_o,
  output logic             gray_valid_o,
  input  logic             gray_ready_i,
  output logic [2:0]       en_o
`ifdef GRAY_ENC_CHECK_EN
 ,output logic             err_o
`endif
);

`ifdef GRAY_ENC_CHECK_EN
  localparam int BUF_W = WIDTH + 1;
`else
  localparam int BUF_W = WIDTH;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             out_en_q;
  logic             push, full;
  logic [WIDTH-1:0] enc_src, gray_word;
  logic [BUF_W-1:0] buf_din, buf_dout;

  // out_en_q keeps bin_ready_o low for the first cycle after reset.
  assign bin_ready_o = (state_q == IDLE) && out_en_q && !full && !start_i;
  assign enc_src     = (state_q == COUNT) ? cnt_q : bin_i;
  assign gray_word   = WIDTH'(bin2gray(32'(enc_src)));
  assign done_o      = (state_q == DONE);
  assign en_o        = gray_valid_o ? EN_ACTIVE : EN_IDLE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          cnt_d   = first_i;
          last_d  = last_i;
          state_d = COUNT;
        end else if (bin_valid_i && bin_ready_o) begin
          push = 1'b1;
        end
      end
      COUNT: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (!full) begin
          push  = 1'b1;
          cnt_d = cnt_q + WIDTH'(1);
          if (cnt_q == last_q) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= '0;
      out_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      out_en_q <= 1'b1;
    end
  end

`ifdef GRAY_ENC_CHECK_EN
  // Each buffered word carries a tag bit marking it as a count-mode word.
  assign buf_din = {(state_q == COUNT), gray_word};
  assign gray_o  = buf_dout[WIDTH-1:0];

  logic [WIDTH-1:0] prev_q, prev_d, diff;
  logic             prev_v_q, prev_v_d;
  logic             err_q, err_d;

  always_comb begin
    prev_d   = prev_q;
    prev_v_d = prev_v_q;
    err_d    = err_q;
    diff     = prev_q ^ gray_o;
    if (gray_valid_o && gray_ready_i) begin
      if (buf_dout[WIDTH]) begin
        if (prev_v_q && !((diff != '0) && ((diff & (diff - WIDTH'(1))) == '0))) err_d = 1'b1;
        prev_d   = gray_o;
        prev_v_d = 1'b1;
      end else begin
        prev_v_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q   <= '0;
      prev_v_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      prev_v_q <= prev_v_d;
      err_q    <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign buf_din = gray_word;
  assign gray_o  = buf_dout;
`endif

  gray_obuf #(
    .WIDTH(BUF_W)
  ) u_obuf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .din_i   (buf_din),
    .full_o  (full),
    .valid_o (gray_valid_o),
    .dout_o  (buf_dout),
    .ready_i (gray_ready_i)
  );

endmodule

// File: tb/tb_gray_encoder_stream.sv
// Self-checking bench for gray_encoder_stream: queue-based reference model plus directed literal checks.
module tb_gray_encoder_stream;

  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [W-1:0] bin_i;
  logic         bin_valid_i;
  logic         bin_ready_o;
  logic         start_i;
  logic [W-1:0] first_i;
  logic [W-1:0] last_i;
  logic         abort_i;
  logic         done_o;
  logic [W-1:0] gray_o;
  logic         gray_valid_o;
  logic         gray_ready_i;
  logic [2:0]   en_o;
`ifdef GRAY_ENC_CHECK_EN
  logic         err_o;
`endif

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  gray_encoder_stream #(.WIDTH(W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .bin_i        (bin_i),
    .bin_valid_i  (bin_valid_i),
    .bin_ready_o  (bin_ready_o),
    .start_i      (start_i),
    .first_i      (first_i),
    .last_i       (last_i),
    .abort_i      (abort_i),
    .done_o       (done_o),
    .gray_o       (gray_o),
    .gray_valid_o (gray_valid_o),
    .gray_ready_i (gray_ready_i),
    .en_o         (en_o)
`ifdef GRAY_ENC_CHECK_EN
   ,.err_o        (err_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic         tag;
    logic [W-1:0] word;
  } item_t;

  typedef enum int {M_IDLE, M_COUNT, M_DONE} mmode_t;

  item_t        mq[$];
  mmode_t       m_mode = M_IDLE;
  logic [W-1:0] m_cnt, m_last, m_prev;
  bit           m_ready_en = 1'b0;
  bit           m_err = 1'b0;
  bit           m_prev_v = 1'b0;

  // Bitwise definition: top bit copies, every lower bit is the xor of its binary neighbours.
  function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
    logic [W-1:0] g;
    g[W-1] = b[W-1];
    for (int i = 0; i < W-1; i++) g[i] = b[i] ^ b[i+1];
    return g;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  always @(posedge clk_i) begin : model
    item_t it, p;
    bit    do_push, full;
    if (rst_i) begin
      mq.delete();
      m_mode     = M_IDLE;
      m_cnt      = '0;
      m_last     = '0;
      m_ready_en = 1'b0;
      m_err      = 1'b0;
      m_prev_v   = 1'b0;
    end else begin
      full    = (mq.size() == 2);
      do_push = 1'b0;
      it      = '0;
      case (m_mode)
        M_IDLE: begin
          if (start_i) begin
            m_cnt  = first_i;
            m_last = last_i;
            m_mode = M_COUNT;
          end else if (bin_valid_i && m_ready_en && !full) begin
            it.tag  = 1'b0;
            it.word = to_gray(bin_i);
            do_push = 1'b1;
          end
        end
        M_COUNT: begin
          if (abort_i) begin
            m_mode = M_IDLE;
          end else if (!full) begin
            it.tag  = 1'b1;
            it.word = to_gray(m_cnt);
            do_push = 1'b1;
            if (m_cnt == m_last) m_mode = M_DONE;
            m_cnt = m_cnt + W'(1);
          end
        end
        default: m_mode = M_IDLE;
      endcase
      if (mq.size() > 0 && gray_ready_i) begin
        p = mq.pop_front();
        if (p.tag) begin
          if (m_prev_v && $countones(m_prev ^ p.word) != 1) m_err = 1'b1;
          m_prev   = p.word;
          m_prev_v = 1'b1;
        end else begin
          m_prev_v = 1'b0;
        end
      end
      if (do_push) mq.push_back(it);
      m_ready_en = 1'b1;
    end
  end

  always @(negedge clk_i) begin
    if (check_en) begin
      checkOutput("valid", {31'd0, gray_valid_o}, {31'd0, mq.size() > 0});
      checkOutput("en", {29'd0, en_o}, (mq.size() > 0) ? 32'd4 : 32'd0);
      checkOutput("done", {31'd0, done_o}, {31'd0, m_mode == M_DONE});
      checkOutput("bin_ready", {31'd0, bin_ready_o},
                  {31'd0, m_ready_en && m_mode == M_IDLE && mq.size() < 2 && !start_i});
      if (mq.size() > 0) checkOutput("gray", {24'd0, gray_o}, {24'd0, mq[0].word});
`ifdef GRAY_ENC_CHECK_EN
      checkOutput("err", {31'd0, err_o}, {31'd0, m_err});
`endif
    end
  end

  logic [7:0] exp_wrap [4] = '{8'h81, 8'h80, 8'h00, 8'h01};
  logic [7:0] exp_bp   [8] = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04};
  logic [7:0] exp_abt  [3] = '{8'h00, 8'h01, 8'h03};
  logic [7:0] got      [16];
  int         n, dones;
  logic       pre_pop;
  logic [7:0] pre_word;

  initial begin
    rst_i = 1'b1; bin_i = '0; bin_valid_i = 1'b0; start_i = 1'b0;
    first_i = '0; last_i = '0; abort_i = 1'b0; gray_ready_i = 1'b1;

    applyStimulus(1);
    check_en = 1'b1;
    applyStimulus(1);
    checkOutput("rst_gray", {24'd0, gray_o}, 32'd0);
    checkOutput("rst_valid", {31'd0, gray_valid_o}, 32'd0);
    checkOutput("rst_en", {29'd0, en_o}, 32'd0);
    checkOutput("rst_ready", {31'd0, bin_ready_o}, 32'd0);
    checkOutput("rst_done", {31'd0, done_o}, 32'd0);
    rst_i = 1'b0;
    applyStimulus(1);
    checkOutput("post_rst_ready", {31'd0, bin_ready_o}, 32'd1);

    bin_i = 8'h05; bin_valid_i = 1'b1;
    applyStimulus(1);
    checkOutput("pt_05", {24'd0, gray_o}, 32'h07);
    checkOutput("pt_05_en", {29'd0, en_o}, 32'd4);
    bin_i = 8'hFF;
    applyStimulus(1);
    checkOutput("pt_ff", {24'd0, gray_o}, 32'h80);
    bin_valid_i = 1'b0;
    applyStimulus(1);
    checkOutput("pt_idle_en", {29'd0, en_o}, 32'd0);

    first_i = 8'hFE; last_i = 8'h01; start_i = 1'b1;
    applyStimulus(1);
    start_i = 1'b0;
    n = 0; dones = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1);
      if (gray_valid_o && n < 16) begin got[n] = gray_o; n++; end
      if (done_o) dones++;
    end
    checkOutput("wrap_count", n, 4);
    for (int i = 0; i < 4; i++) checkOutput("wrap_word", {24'd0, got[i]}, {24'd0, exp_wrap[i]});
    checkOutput("wrap_done", dones, 1);
    checkOutput("wrap_ready", {31'd0, bin_ready_o}, 32'd1);
`ifdef GRAY_ENC_CHECK_EN
    checkOutput("wrap_err", {31'd0, err_o}, 32'd0);
`endif

    first_i = 8'h00; last_i = 8'h07; start_i = 1'b1;
    applyStimulus(1);
    start_i = 1'b0;
    n = 0;
    for (int i = 0; i < 64 && n < 8; i++) begin
      gray_ready_i = ((i % 4) == 0) || ((i % 4) == 3);
      pre_pop  = gray_valid_o && gray_ready_i;
      pre_word = gray_o;
      applyStimulus(1);
      if (pre_pop) begin got[n] = pre_word; n++; end
    end
    gray_ready_i = 1'b1;
    checkOutput("bp_count", n, 8);
    for (int i = 0; i < 8; i++) checkOutput("bp_word", {24'd0, got[i]}, {24'd0, exp_bp[i]});
    applyStimulus(3);

    first_i = 8'h00; last_i = 8'h0A; start_i = 1'b1;
    applyStimulus(1);
    start_i = 1'b0;
    n = 0; dones = 0;
    for (int i = 0; i < 8; i++) begin
      abort_i = (i == 3);
      applyStimulus(1);
      if (gray_valid_o && n < 16) begin got[n] = gray_o; n++; end
      if (done_o) dones++;
    end
    abort_i = 1'b0;
    checkOutput("abort_count", n, 3);
    for (int i = 0; i < 3; i++) checkOutput("abort_word", {24'd0, got[i]}, {24'd0, exp_abt[i]});
    checkOutput("abort_done", dones, 0);
    checkOutput("abort_en", {29'd0, en_o}, 32'd0);

    bin_i = 8'h33; bin_valid_i = 1'b1; start_i = 1'b1; first_i = 8'h10; last_i = 8'h10;
    #1;
    checkOutput("coll_ready", {31'd0, bin_ready_o}, 32'd0);
    applyStimulus(1);
    start_i = 1'b0; bin_valid_i = 1'b0;
    n = 0; dones = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1);
      if (gray_valid_o && n < 16) begin got[n] = gray_o; n++; end
      if (done_o) dones++;
    end
    checkOutput("coll_count", n, 1);
    checkOutput("coll_word", {24'd0, got[0]}, 32'h18);
    checkOutput("coll_done", dones, 1);

    gray_ready_i = 1'b0; first_i = 8'h20; last_i = 8'h2F; start_i = 1'b1;
    applyStimulus(1);
    start_i = 1'b0;
    applyStimulus(2);
    checkOutput("midrst_pre_gray", {24'd0, gray_o}, 32'h30);
    rst_i = 1'b1;
    applyStimulus(1);
    checkOutput("midrst_gray", {24'd0, gray_o}, 32'd0);
    checkOutput("midrst_valid", {31'd0, gray_valid_o}, 32'd0);
    checkOutput("midrst_en", {29'd0, en_o}, 32'd0);
    checkOutput("midrst_ready", {31'd0, bin_ready_o}, 32'd0);
    checkOutput("midrst_done", {31'd0, done_o}, 32'd0);
    rst_i = 1'b0;
    applyStimulus(1);
    checkOutput("midrst_ready_after", {31'd0, bin_ready_o}, 32'd1);

    for (int i = 0; i < 1500; i++) begin
      rst_i        = ($urandom_range(0, 199) == 0);
      bin_i        = W'($urandom);
      bin_valid_i  = $urandom_range(0, 1) == 1;
      start_i      = ($urandom_range(0, 15) == 0);
      first_i      = W'($urandom);
      last_i       = first_i + W'($urandom_range(0, 5));
      abort_i      = ($urandom_range(0, 31) == 0);
      gray_ready_i = ($urandom_range(0, 9) < 7);
      applyStimulus(1);
    end

    rst_i = 1'b0; bin_valid_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; gray_ready_i = 1'b1;
    applyStimulus(20);
    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
